// File: rtl/fmap_streamer_if.sv
// Output stream bundle of fmap_streamer: one map word per transfer with its raster index and last marker.
interface fmap_streamer_if #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 10
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_idx;
    logic              out_last;

    modport master (output out_valid, output out_data, output out_idx, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_idx, input out_last, output out_ready);
endinterface

// File: rtl/fmap_streamer.sv
// fmap_streamer: reads the layer-1 pooled map from result memory in raster order and streams it
// on a valid/ready port. Define FMAP_STREAMER_CHECKSUM_EN to build the per-frame checksum.
module fmap_streamer #(
    parameter int         DATA_W     = 20,
    parameter int         ADDR_W     = 10,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [2:0] LAYER_SEL  = 3'b011
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               crd,
    output logic [2:0]         csel,
    output logic [11:0]        caddr_rd,
    input  logic [DATA_W-1:0]  cdata_rd,
    fmap_streamer_if.master    strm,
    output logic [31:0]        checksum
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_DRAIN = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t            state_r, state_s;
    logic              issue_s, start_acc_s, credit_ok_s, valid_s, pop_s, last_s;
    logic [ADDR_W-1:0] idx_s;
    logic [CNT_W-1:0]  count_r, count_s;
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [DATA_W-1:0] fifo_mem_r [FIFO_DEPTH];
    logic [ADDR_W-1:0] rd_idx_r, caddr_r, out_cnt_r;
    logic              pend_r, crd_r, busy_r, done_r;
    logic [2:0]        csel_r;

    assign valid_s = (count_r != {CNT_W{1'b0}});
    assign pop_s   = valid_s & strm.out_ready;
    assign last_s  = (out_cnt_r == LAST_IDX);
    assign count_s = count_r + CNT_W'(pend_r) - CNT_W'(pop_s);
    // Room is needed for the word landing from the previous read plus the read being issued.
    assign credit_ok_s = (SUM_W'(count_s) + SUM_W'(crd_r) + SUM_W'(1'b1)) <= SUM_W'(FIFO_DEPTH);

    // Next-state, read-issue and start-acceptance decisions.
    always_comb begin
        state_s     = state_r;
        issue_s     = 1'b0;
        start_acc_s = 1'b0;
        idx_s       = rd_idx_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    start_acc_s = 1'b1;
                    issue_s     = 1'b1;
                    idx_s       = {ADDR_W{1'b0}};
                    state_s     = S_RUN;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (credit_ok_s) begin
                    issue_s = 1'b1;
                    if (rd_idx_r == LAST_IDX) begin
                        state_s = S_DRAIN;
                    end else begin
                        state_s = S_RUN;
                    end
                end else begin
                    state_s = S_RUN;
                end
            end
            S_DRAIN: begin
                if (pop_s && last_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_DRAIN;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Control registers, read port, FIFO pointers and output index counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            crd_r     <= 1'b0;
            csel_r    <= 3'b000;
            caddr_r   <= {ADDR_W{1'b0}};
            rd_idx_r  <= {ADDR_W{1'b0}};
            pend_r    <= 1'b0;
            count_r   <= {CNT_W{1'b0}};
            wr_ptr_r  <= {PTR_W{1'b0}};
            rd_ptr_r  <= {PTR_W{1'b0}};
            out_cnt_r <= {ADDR_W{1'b0}};
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == S_RUN) || (state_s == S_DRAIN);
            done_r  <= (state_s == S_DONE);
            crd_r   <= issue_s;
            csel_r  <= issue_s ? LAYER_SEL : 3'b000;
            pend_r  <= crd_r;
            count_r <= count_s;
            if (issue_s) begin
                caddr_r  <= idx_s;
                rd_idx_r <= idx_s + ADDR_W'(1'b1);
            end
            if (pend_r) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            if (start_acc_s) begin
                out_cnt_r <= {ADDR_W{1'b0}};
            end else if (pop_s) begin
                out_cnt_r <= out_cnt_r + ADDR_W'(1'b1);
            end
        end
    end

    // FIFO storage; left unreset because outputs are gated by out_valid.
    always_ff @(posedge clk) begin
        if (pend_r) begin
            fifo_mem_r[wr_ptr_r] <= cdata_rd;
        end
    end

    assign strm.out_valid = valid_s;
    assign strm.out_data  = valid_s ? fifo_mem_r[rd_ptr_r] : {DATA_W{1'b0}};
    assign strm.out_idx   = valid_s ? out_cnt_r : {ADDR_W{1'b0}};
    assign strm.out_last  = valid_s & last_s;
    assign busy           = busy_r;
    assign done           = done_r;
    assign crd            = crd_r;
    assign csel           = csel_r;
    assign caddr_rd       = 12'(caddr_r);

`ifdef FMAP_STREAMER_CHECKSUM_EN
    logic [31:0] csum_r;

    // Frame checksum: cleared on accepted start, accumulates every transferred word.
    always_ff @(posedge clk) begin
        if (reset) begin
            csum_r <= 32'h0000_0000;
        end else if (start_acc_s) begin
            csum_r <= 32'h0000_0000;
        end else if (pop_s) begin
            csum_r <= csum_r + 32'(strm.out_data);
        end else begin
            csum_r <= csum_r;
        end
    end

    assign checksum = csum_r;
`else
    assign checksum = 32'h0000_0000;
`endif
endmodule

// File: tb/tb_fmap_streamer.sv
`timescale 1ns/1ps
// Scoreboard bench for fmap_streamer: directed frames (full rate, backpressure, ignored starts,
// mid-frame reset, checksum patterns) with expected words queued and checked by a separate monitor.
module tb_fmap_streamer;
    localparam int N = 1024;

    logic        clk = 1'b0;
    logic        reset, start, busy, done, crd;
    logic [2:0]  csel;
    logic [11:0] caddr_rd;
    logic [19:0] cdata_rd;
    logic [31:0] checksum;

    fmap_streamer_if #(.DATA_W(20), .ADDR_W(10)) sif ();

    fmap_streamer #(.DATA_W(20), .ADDR_W(10), .FIFO_DEPTH(4), .LAYER_SEL(3'b011)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .crd(crd),
        .csel(csel), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .strm(sif), .checksum(checksum));

    always #5 clk = ~clk;

    int n_checks = 0, n_errs = 0, cyc = 0, pat = 0, rmode = 0, start_cyc = 0;
    logic [30:0] exp_q[$];
    int rd_exp = 0, issued = 0, xfer_cnt = 0, max_out = 0;
    int first_valid_cyc = -1, last_xfer_cyc = 0, done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [19:0] memval(input int p, input int i);
        case (p)
            0:       return 20'(i * 3);
            1:       return 20'hFFFFF;
            default: return 20'h00001;
        endcase
    endfunction

    function automatic logic [31:0] cs_exp(input int p);
`ifdef FMAP_STREAMER_CHECKSUM_EN
        case (p)
            0:       return 32'h0017_FA00;
            1:       return 32'h3FFF_FC00;
            default: return 32'h0000_0400;
        endcase
`else
        return 32'h0000_0000;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Result memory with one-cycle read latency.
    always @(posedge clk) cdata_rd <= crd ? memval(pat, int'(caddr_rd[9:0])) : 20'h00000;

    // Monitor: read-port checks, credit bound, stall stability and scoreboard compare.
    initial begin
        logic [30:0] e;
        logic        prev_stall;
        logic [19:0] prev_data;
        logic [9:0]  prev_idx;
        logic        prev_last;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                prev_stall = 1'b0;
                issued = 0; xfer_cnt = 0; rd_exp = 0;
            end else begin
                if (start && !busy && !done) begin
                    rd_exp = 0; issued = 0; xfer_cnt = 0; max_out = 0;
                    first_valid_cyc = -1; done_cnt = 0;
                end
                if (crd) begin
                    check("rd_csel", 32'(csel), 32'h3);
                    check("rd_addr", 32'(caddr_rd), 32'(rd_exp));
                    rd_exp++; issued++;
                end else begin
                    check("idle_csel", 32'(csel), 32'h0);
                end
                if (issued - xfer_cnt > max_out) max_out = issued - xfer_cnt;
                check("credit_bound", 32'(issued - xfer_cnt <= 4), 32'h1);
`ifndef FMAP_STREAMER_CHECKSUM_EN
                check("checksum_zero", checksum, 32'h0);
`endif
                if (prev_stall) begin
                    check("stall_valid", 32'(sif.out_valid), 32'h1);
                    check("stall_data", 32'(sif.out_data), 32'(prev_data));
                    check("stall_idx", 32'(sif.out_idx), 32'(prev_idx));
                    check("stall_last", 32'(sif.out_last), 32'(prev_last));
                end
                if (sif.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (sif.out_valid && sif.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_xfer", 32'h1, 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", 32'(sif.out_data), 32'(e[19:0]));
                        check("out_idx", 32'(sif.out_idx), 32'(e[29:20]));
                        check("out_last", 32'(sif.out_last), 32'(e[30]));
                    end
                    xfer_cnt++;
                    last_xfer_cyc = cyc;
                end
                prev_stall = sif.out_valid && !sif.out_ready;
                prev_data  = sif.out_data;
                prev_idx   = sif.out_idx;
                prev_last  = sif.out_last;
                if (done) done_cnt++;
            end
        end
    end

    // Downstream ready: always high, or 1,0,0,1 with a 50-cycle low window at word 500.
    initial begin
        int  low_left;
        bit  win_done;
        low_left = 0; win_done = 1'b0;
        sif.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rmode == 0) begin
                win_done = 1'b0; low_left = 0; sif.out_ready = 1'b1;
            end else begin
                if (!win_done && xfer_cnt == 500) begin
                    low_left = 50; win_done = 1'b1;
                end
                if (low_left > 0) begin
                    low_left--; sif.out_ready = 1'b0;
                end else begin
                    sif.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic launch(input int p);
        pat = p;
        for (int i = 0; i < N; i++) exp_q.push_back({(i == N - 1), 10'(i), memval(p, i)});
        start = 1'b1; start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 6000) begin tick(); k++; end
        if (!done) check("done_timeout", 32'h0, 32'h1);
    endtask

    task automatic end_frame(input int p);
        check("done_checksum", checksum, cs_exp(p));
        repeat (5) tick();
        check("checksum_hold", checksum, cs_exp(p));
        check("busy_after", 32'(busy), 32'h0);
        check("done_pulses", 32'(done_cnt), 32'h1);
        check("word_count", 32'(xfer_cnt), 32'(N));
        check("queue_empty", 32'(exp_q.size()), 32'h0);
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_crd", 32'(crd), 32'h0);
        check("rst_csel", 32'(csel), 32'h0);
        check("rst_caddr", 32'(caddr_rd), 32'h0);
        check("rst_valid", 32'(sif.out_valid), 32'h0);
        check("rst_data", 32'(sif.out_data), 32'h0);
        check("rst_idx", 32'(sif.out_idx), 32'h0);
        check("rst_last", 32'(sif.out_last), 32'h0);
        check("rst_checksum", checksum, 32'h0);
    endtask

    initial begin
        int k;
        reset = 1'b1; start = 1'b0;
        repeat (3) tick();
        check_reset_outputs();
        reset = 1'b0;
        tick();

        // Full-rate frame with latency checks.
        launch(0);
        wait_done();
        check("lat_first_valid", 32'(first_valid_cyc), 32'(start_cyc + 3));
        check("lat_last_xfer", 32'(last_xfer_cyc), 32'(start_cyc + 1026));
        check("lat_done", 32'(cyc), 32'(last_xfer_cyc + 1));
        end_frame(0);

        // Backpressure frame.
        rmode = 1;
        launch(0);
        wait_done();
        end_frame(0);
        check("max_outstanding", 32'(max_out), 32'h4);
        rmode = 0;
        tick();

        // Extra start pulses mid-frame and in the DONE cycle.
        launch(0);
        for (int c = 1; c < 6000 && !done; c++) begin
            start = (c == 10 || c == 600);
            tick();
        end
        start = 1'b0;
        if (!done) check("done_timeout_ign", 32'h0, 32'h1);
        start = 1'b1;
        tick();
        start = 1'b0;
        end_frame(0);

        // Reset after word 300 transfers, then a fresh frame.
        launch(0);
        k = 0;
        while (xfer_cnt < 301 && k < 3000) begin tick(); k++; end
        check("reached_300", 32'(xfer_cnt >= 301), 32'h1);
        reset = 1'b1;
        tick();
        check_reset_outputs();
        reset = 1'b0;
        tick();
        launch(0);
        wait_done();
        end_frame(0);

        // Checksum patterns.
        launch(1);
        wait_done();
        end_frame(1);
        launch(2);
        wait_done();
        end_frame(2);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
